glitch_filter: RTL and testbench
================================

// Module: glitch_filter
// PURPOSE
//  Receiving end for the gate-level hazard networks in this library, whose outputs glitch from
//  unequal gate delays. Samples such an output, produces a clean level only after the input has
//  held a new value for STABLE_CYCLES clocks, and counts rejected glitches for hazard analysis.
//  Placed between any delay-annotated combinational block and clocked downstream logic.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive sampled cycles a new level must hold before dout follows (>=1)
//  CNT_W          8  width of glitch counter; saturates at 2^CNT_W-1
//  RESET_VAL      0  value of dout and of all sample flops during reset
// PORTS
//  clk          input   1      single clock, rising edge
//  rst_n        input   1      asynchronous active-low reset
//  din          input   1      raw (possibly glitching) combinational output, asynchronous to clk
//  clr          input   1      synchronous clear of glitch_cnt
//  dout         output  1      filtered level
//  rise         output  1      1-cycle pulse when dout goes 0->1
//  fall         output  1      1-cycle pulse when dout goes 1->0
//  glitch_pulse output  1      1-cycle pulse when a pending change is abandoned
//  glitch_cnt   output  CNT_W  saturating count of abandoned changes
// BEHAVIOUR
//  - Reset (rst_n low, async): dout=RESET_VAL, sample flops=RESET_VAL, cnt=0, rise=fall=0,
//    glitch_pulse=0, glitch_cnt=0. Takes effect immediately, incl. mid-pending change.
//  - Sample stage s: 2-flop synchronizer on din (see CONFIGURATION).
//  - States: IDLE (cnt==0), PEND (cnt!=0). cnt width = clog2(STABLE_CYCLES)+1.
//  - Each edge, s!=dout: if cnt==STABLE_CYCLES-1 -> dout<=s, cnt<=0, rise/fall pulse per
//    direction; else cnt<=cnt+1 (IDLE->PEND).
//  - Each edge, s==dout: cnt<=0; if cnt!=0 (was PEND) -> glitch_pulse=1, glitch_cnt+=1 (sat).
//  - STABLE_CYCLES=1: dout follows s one edge later; glitch_pulse never asserts.
//  - Latency (sync on): din change captured at edge E -> dout updates at edge E+STABLE_CYCLES+1;
//    rise/fall asserted in the cycle dout takes its new value.
//  - Pulses shorter than one clock period may be missed entirely; not counted, not an error.
//  - rise, fall, glitch_pulse registered, mutually exclusive, high exactly one cycle per event.
//  - clr and glitch on same edge: clr wins, glitch_cnt=0; glitch_pulse still asserts.
//  - glitch_cnt at max: stays at 2^CNT_W-1, glitch_pulse still asserts; no wrap.
// CONFIGURATION
//  GLITCH_FILTER_SYNC_EN defined: s = second of two flops on din (metastability-safe).
//  Not defined: s = single flop on din; all latencies shrink by one edge
//  (dout updates at edge E+STABLE_CYCLES). Counting, pulses, saturation unchanged.
// TESTING (defaults, GLITCH_FILTER_SYNC_EN defined unless noted)
//  1 Reset: rst_n=0 mid-run -> dout=0, rise=fall=glitch_pulse=0, glitch_cnt=0 same cycle.
//  2 Step: din 0->1 held 10 clk -> dout=1 5 edges after capture, rise high exactly 1 cycle.
//  3 Glitch: din=1 for 2 clk -> dout stays 0, glitch_pulse once, glitch_cnt=1, no rise.
//  4 Saturation: CNT_W=2, five 2-clk glitches -> glitch_cnt=3, five glitch_pulses.
//  5 clr coincident with 3rd glitch -> glitch_cnt=0 next cycle; next glitch -> 1.
//  6 Macro off: step 0->1 -> dout=1 4 edges after capture; 1->0 gives fall pulse 1 cycle.

Source files
------------

// File: rtl/glitch_filter.sv
// Debounces a glitching combinational signal into a clean level and counts abandoned changes.
// Build option: define GLITCH_FILTER_SYNC_EN for a two-flop synchronizer on din (else one flop).
module glitch_filter #(
   parameter int   STABLE_CYCLES = 4,
   parameter int   CNT_W         = 8,
   parameter logic RESET_VAL     = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   input  logic             clr,
   output logic             dout,
   output logic             rise,
   output logic             fall,
   output logic             glitch_pulse,
   output logic [CNT_W-1:0] glitch_cnt
);

   localparam int             CW        = $clog2(STABLE_CYCLES) + 1;
   localparam logic [CW-1:0]  LAST      = CW'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GCNT_MAX = {CNT_W{1'b1}};

   typedef enum logic {IDLE, PEND} state_e;

   logic             s_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dout_q, dout_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             glitch_q, glitch_d;
   logic [CNT_W-1:0] gcnt_q, gcnt_d;
   state_e           state;

`ifdef GLITCH_FILTER_SYNC_EN
   logic meta_q;

   // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         s_q    <= RESET_VAL;
      end else begin
         meta_q <= din;
         s_q    <= meta_q;
      end
   end
`else
   // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s_q <= RESET_VAL;
      else        s_q <= din;
   end
`endif

   assign state = (cnt_q == '0) ? IDLE : PEND;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      cnt_d    = cnt_q;
      dout_d   = dout_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      glitch_d = 1'b0;
      gcnt_d   = gcnt_q;
      if (s_q != dout_q) begin
         if (cnt_q == LAST) begin
            dout_d = s_q;
            cnt_d  = '0;
            rise_d = s_q;
            fall_d = ~s_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else begin
         cnt_d = '0;
         // Returning to the committed level while pending means the change was a glitch.
         if (state == PEND) begin
            glitch_d = 1'b1;
            if (gcnt_q != GCNT_MAX) gcnt_d = gcnt_q + CNT_W'(1);
         end
      end
      if (clr) gcnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         dout_q   <= RESET_VAL;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         glitch_q <= 1'b0;
         gcnt_q   <= '0;
      end else begin
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         glitch_q <= glitch_d;
         gcnt_q   <= gcnt_d;
      end
   end

   assign dout         = dout_q;
   assign rise         = rise_q;
   assign fall         = fall_q;
   assign glitch_pulse = glitch_q;
   assign glitch_cnt   = gcnt_q;

endmodule

// File: tb/tb_glitch_filter.sv
// Directed bench for glitch_filter: a default instance plus a CNT_W=2 instance for saturation.
module tb_glitch_filter;

   localparam int STABLE = 4;
`ifdef GLITCH_FILTER_SYNC_EN
   localparam int SYNC_X = 1;
`else
   localparam int SYNC_X = 0;
`endif
   // Ticks after driving din during which dout must still hold its old value.
   localparam int NLAT = STABLE + SYNC_X;
   // Tick on which a 2-cycle glitch is abandoned and glitch_pulse appears.
   localparam int GL   = 4 + SYNC_X;

   logic       clk, rst_n, din, clr;
   logic       dout, rise, fall, glitch_pulse;
   logic [7:0] glitch_cnt;
   logic       dout_s, rise_s, fall_s, gp_s;
   logic [1:0] gcnt_s;

   int checks = 0;
   int errors = 0;

   glitch_filter #(.STABLE_CYCLES(STABLE), .CNT_W(8), .RESET_VAL(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .clr(clr),
      .dout(dout), .rise(rise), .fall(fall),
      .glitch_pulse(glitch_pulse), .glitch_cnt(glitch_cnt)
   );

   glitch_filter #(.STABLE_CYCLES(STABLE), .CNT_W(2), .RESET_VAL(1'b0)) dut_sat (
      .clk(clk), .rst_n(rst_n), .din(din), .clr(clr),
      .dout(dout_s), .rise(rise_s), .fall(fall_s),
      .glitch_pulse(gp_s), .glitch_cnt(gcnt_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a new level and hold it for 10 clocks, checking exact latency and edge pulses.
   task automatic step(input logic v);
      din = v;
      for (int e = 1; e <= NLAT; e++) begin
         tick();
         check("step_hold", {31'b0, dout}, {31'b0, ~v});
         check("step_no_edge", {30'b0, rise, fall}, 32'd0);
      end
      tick();
      check("step_dout", {31'b0, dout}, {31'b0, v});
      check("step_rise", {31'b0, rise}, {31'b0, v});
      check("step_fall", {31'b0, fall}, {31'b0, ~v});
      check("step_sat_dout", {31'b0, dout_s}, {31'b0, v});
      tick();
      check("step_pulse_end", {30'b0, rise, fall}, 32'd0);
      for (int e = NLAT + 3; e <= 10; e++) tick();
   endtask

   // din high for two captured clocks from a low dout; optionally clr on the glitch edge.
   task automatic glitch(input logic with_clr);
      int gp, gps, bad;
      gp = 0; gps = 0; bad = 0;
      din = 1'b1;
      for (int e = 1; e <= GL + 2; e++) begin
         if (e == 3) din = 1'b0;
         if (with_clr && e == GL) clr = 1'b1;
         tick();
         clr = 1'b0;
         if (e == GL) check("glitch_edge", {31'b0, glitch_pulse}, 32'd1);
         gp  += int'(glitch_pulse);
         gps += int'(gp_s);
         bad += int'(rise | fall | dout | rise_s | dout_s);
      end
      check("glitch_pulses", gp, 1);
      check("glitch_pulses_sat", gps, 1);
      check("glitch_no_rise", bad, 0);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_cnt", {24'b0, glitch_cnt}, 32'd0);
      check("clr_cnt_sat", {30'b0, gcnt_s}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; din = 1'b0; clr = 1'b0;
      #12;
      check("rst_dout", {31'b0, dout}, 32'd0);
      check("rst_pulses", {29'b0, rise, fall, glitch_pulse}, 32'd0);
      check("rst_cnt", {24'b0, glitch_cnt}, 32'd0);
      rst_n = 1'b1;
      repeat (3) tick();

      step(1'b1);
      step(1'b0);

      glitch(1'b0);
      check("g1_cnt", {24'b0, glitch_cnt}, 32'd1);

      pulse_clr();
      for (int i = 1; i <= 5; i++) begin
         glitch(1'b0);
         check("sat_full_cnt", {24'b0, glitch_cnt}, i);
         check("sat_cnt", {30'b0, gcnt_s}, (i > 3) ? 3 : i);
      end

      pulse_clr();
      glitch(1'b0);
      glitch(1'b0);
      check("pre_clr_cnt", {24'b0, glitch_cnt}, 32'd2);
      glitch(1'b1);
      check("clr_wins_cnt", {24'b0, glitch_cnt}, 32'd0);
      check("clr_wins_sat", {30'b0, gcnt_s}, 32'd0);
      glitch(1'b0);
      check("after_clr_cnt", {24'b0, glitch_cnt}, 32'd1);

      step(1'b1);
      din = 1'b0;
      repeat (3) tick();
      #2 rst_n = 1'b0;
      #1;
      check("midrst_dout", {31'b0, dout}, 32'd0);
      check("midrst_pulses", {29'b0, rise, fall, glitch_pulse}, 32'd0);
      check("midrst_cnt", {24'b0, glitch_cnt}, 32'd0);
      #3 rst_n = 1'b1;
      repeat (8) tick();
      check("post_rst_dout", {31'b0, dout}, 32'd0);
      check("post_rst_cnt", {24'b0, glitch_cnt}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
